// File: rtl/serial_sub8_if.sv
// serial_sub8_if: operand/result bundle for the bit-serial subtractor.
//   master : drives start, A, B, Bin; observes busy, done, Diff, Bout, Ovf
//   slave  : the subtractor itself (the inverse directions)
interface serial_sub8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout, Ovf
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout, Ovf
  );
endinterface

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial subtractor, Diff = A - B - Bin, one bit per clock
// through a single full-subtractor cell.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     serial_sub8_if.slave
//             start/A/B/Bin  operands, sampled on the accepting edge (busy=0)
//             busy           high while bits are being processed
//             done           one-cycle pulse when Diff/Bout/Ovf update
//             Diff/Bout/Ovf  result, held until the next operation completes
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub8_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] res_sr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             ovf_reg;

  // Full-subtractor cell on the current LSBs.
  logic a_bit, b_bit, d_bit, br_next;

  always_comb begin
    a_bit   = a_sr_reg[0];
    b_bit   = b_sr_reg[0];
    d_bit   = a_bit ^ b_bit ^ br_reg;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      cnt_reg    <= '0;
      br_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_sr_reg   <= bus.A;
            b_sr_reg   <= bus.B;
            br_reg     <= bus.Bin;
            res_sr_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end else begin
            state_reg  <= IDLE;
          end
        end
        RUN: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          br_reg     <= br_next;
          res_sr_reg <= {d_bit, res_sr_reg[WIDTH-1:1]};
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            // Last bit: the LSBs now hold the operand MSBs and d_bit is the
            // result MSB, so signed overflow is computed right here.
            diff_reg  <= {d_bit, res_sr_reg[WIDTH-1:1]};
            bout_reg  <= br_next;
            ovf_reg   <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.Diff = diff_reg;
  assign bus.Bout = bout_reg;
  assign bus.Ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: self-checking bench for serial_sub8 (WIDTH=8).
module tb_serial_sub8;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_sub8_if #(.WIDTH(W)) bus ();

  serial_sub8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] diff, output logic bout, output logic ovf);
    int full;
    full = int'(a) - int'(b) - int'(bin);
    diff = W'(full);
    bout = (full < 0);
    ovf  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
  endtask

  // Called just after the accepting edge. Returns at the negedge where done=1.
  // lat counts rising edges including the accepting one.
  task automatic wait_done(output int lat, output int busy_cyc, output bit tout);
    lat = 1; busy_cyc = 0; tout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin
        tout = 1'b0;
        return;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bin = bin;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.Diff, bus.Bout, bus.Ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b Diff=%h Bout=%b Ovf=%b expected all 0",
               bus.busy, bus.done, bus.Diff, bus.Bout, bus.Ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors;
    logic [W-1:0] ta [6] = '{8'd9, 8'd3, 8'd12, 8'd0, 8'h80, 8'h7F};
    logic [W-1:0] tb [6] = '{8'd3, 8'd6, 8'd8,  8'd0, 8'h01, 8'hFF};
    logic         tc [6] = '{1'b0, 1'b0, 1'b1,  1'b1, 1'b0,  1'b0};
    logic [W-1:0] xd; logic xb, xo;
    int lat, bc; bit tout;
    for (int i = 0; i < 6; i++) begin
      model(ta[i], tb[i], tc[i], xd, xb, xo);
      launch(ta[i], tb[i], tc[i]);
      wait_done(lat, bc, tout);
      checks++;
      if (tout || {bus.Diff, bus.Bout, bus.Ovf} !== {xd, xb, xo}) begin
        errors++;
        $display("FAIL vec%0d_result: timeout=%0b Diff=%h Bout=%b Ovf=%b expected Diff=%h Bout=%b Ovf=%b",
                 i, tout, bus.Diff, bus.Bout, bus.Ovf, xd, xb, xo);
      end
      checks++;
      if (lat !== W + 1 || bc !== W) begin
        errors++;
        $display("FAIL vec%0d_timing: latency=%0d busy_cycles=%0d expected %0d and %0d",
                 i, lat, bc, W + 1, W);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.Diff !== xd) begin
        errors++;
        $display("FAIL vec%0d_pulse_hold: done=%b Diff=%h expected done=0 Diff=%h", i, bus.done, bus.Diff, xd);
      end
      $display("vec%0d A=%h B=%h Bin=%b -> Diff=%h Bout=%b Ovf=%b", i, ta[i], tb[i], tc[i],
               bus.Diff, bus.Bout, bus.Ovf);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, xd; logic bin, xb, xo;
    int lat, bc; bit tout;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      model(a, b, bin, xd, xb, xo);
      launch(a, b, bin);
      wait_done(lat, bc, tout);
      checks++;
      if (tout || lat !== W + 1 || {bus.Diff, bus.Bout, bus.Ovf} !== {xd, xb, xo}) begin
        errors++;
        $display("FAIL rand%0d: A=%h B=%h Bin=%b got Diff=%h Bout=%b Ovf=%b lat=%0d expected Diff=%h Bout=%b Ovf=%b lat=%0d",
                 i, a, b, bin, bus.Diff, bus.Bout, bus.Ovf, lat, xd, xb, xo, W + 1);
      end
      $display("rand%0d A=%h B=%h Bin=%b -> Diff=%h Bout=%b Ovf=%b", i, a, b, bin, bus.Diff, bus.Bout, bus.Ovf);
    end
  endtask

  task automatic test_ignore_start;
    logic [W-1:0] xd; logic xb, xo;
    int lat, bc; bit tout;
    model(8'd100, 8'd37, 1'b1, xd, xb, xo);
    launch(8'd100, 8'd37, 1'b1);
    repeat (2) @(posedge clk);
    // Third RUN cycle: new request and operand changes must be ignored.
    launch(8'd1, 8'd200, 1'b0);
    bus.A = 8'h55; bus.B = 8'hAA;
    wait_done(lat, bc, tout);
    checks++;
    if (tout || {bus.Diff, bus.Bout, bus.Ovf} !== {xd, xb, xo} || lat !== W - 2) begin
      errors++;
      $display("FAIL ignore_start: Diff=%h Bout=%b Ovf=%b lat=%0d expected Diff=%h Bout=%b Ovf=%b lat=%0d",
               bus.Diff, bus.Bout, bus.Ovf, lat, xd, xb, xo, W - 2);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: busy=%b expected 0", bus.busy);
    end
    $display("ignore_start -> Diff=%h Bout=%b Ovf=%b", bus.Diff, bus.Bout, bus.Ovf);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xd; logic xb, xo;
    int lat, bc; bit tout;
    launch(8'd50, 8'd20, 1'b0);
    wait_done(lat, bc, tout);
    // Still inside the DONE cycle: request the next operation.
    bus.start = 1'b1; bus.A = 8'd20; bus.B = 8'd50; bus.Bin = 1'b1;
    model(8'd20, 8'd50, 1'b1, xd, xb, xo);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, bc, tout);
    checks++;
    if (tout || lat !== W + 1 || {bus.Diff, bus.Bout, bus.Ovf} !== {xd, xb, xo}) begin
      errors++;
      $display("FAIL back_to_back: Diff=%h Bout=%b Ovf=%b lat=%0d expected Diff=%h Bout=%b Ovf=%b lat=%0d",
               bus.Diff, bus.Bout, bus.Ovf, lat, xd, xb, xo, W + 1);
    end
    $display("back_to_back A=14 B=32 Bin=1 -> Diff=%h Bout=%b Ovf=%b", bus.Diff, bus.Bout, bus.Ovf);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] xd; logic xb, xo;
    int lat, bc, dcount; bit tout;
    launch(8'd9, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.Diff, bus.Bout, bus.Ovf} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b Diff=%h Bout=%b Ovf=%b expected all 0",
               bus.busy, bus.done, bus.Diff, bus.Bout, bus.Ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
    end
    checks++;
    if (dcount !== 0) begin
      errors++;
      $display("FAIL reset_mid_abort: busy/done seen %0d times expected 0", dcount);
    end
    model(8'd5, 8'd7, 1'b1, xd, xb, xo);
    launch(8'd5, 8'd7, 1'b1);
    wait_done(lat, bc, tout);
    checks++;
    if (tout || lat !== W + 1 || {bus.Diff, bus.Bout, bus.Ovf} !== {xd, xb, xo}) begin
      errors++;
      $display("FAIL after_reset: Diff=%h Bout=%b Ovf=%b lat=%0d expected Diff=%h Bout=%b Ovf=%b lat=%0d",
               bus.Diff, bus.Bout, bus.Ovf, lat, xd, xb, xo, W + 1);
    end
    $display("after_reset A=05 B=07 Bin=1 -> Diff=%h Bout=%b Ovf=%b", bus.Diff, bus.Bout, bus.Ovf);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sub8.md
Name: serial_sub8

Overview:
- Bit-serial subtractor: computes Diff = A - B - Bin over WIDTH clock cycles using a single full-subtractor cell and shift registers.
- It is the inverse-direction companion to the team's 8-bit ripple-carry adder, which computes A + B + Cin combinationally.
- Used in area-constrained datapaths, and as a cross-check against the adder: (A + B + Cin) - B - Cin must equal A.
- Operands are loaded through a start/busy handshake. The result is held with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to load operands; accepted only when busy=0.
- A  input  WIDTH  minuend, sampled on the accepting edge.
- B  input  WIDTH  subtrahend, sampled on the accepting edge.
- Bin  input  1  borrow-in, sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- Diff  output  WIDTH  (A - B - Bin) mod 2^WIDTH.
- Bout  output  1  borrow-out: 1 iff A < B + Bin (unsigned).
- Ovf  output  1  signed (two's-complement) overflow of A - B - Bin.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - FSM goes to IDLE; operation aborted, no done pulse.
  - Outputs: busy=0, done=0, Diff=0, Bout=0, Ovf=0.
  - Internal shift registers, bit counter and borrow flop cleared.
- FSM states:
  - IDLE: busy=0. If start=1 at a rising edge, latch A, B, Bin into shift regs / borrow flop; counter=0; go to RUN.
  - RUN: busy=1. Each edge processes LSB of shift regs:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
    - d shifted into the result reg from the MSB side; counter increments.
    - After the edge processing bit WIDTH-1, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle.
    - Diff, Bout (final borrow), Ovf registered on entry to DONE.
    - Ovf = (A[W-1] != B[W-1]) && (Diff[W-1] != A[W-1]), using the latched operands.
    - start=1 in DONE is accepted (back-to-back) → RUN. Otherwise → IDLE.
- Latency: start accepted at edge k. Bits processed at edges k+1..k+WIDTH. done=1 and the result is valid in the cycle after edge k+WIDTH. Start-to-done = WIDTH+1 edges.
- Diff/Bout/Ovf hold their last value until the next operation completes; they are not updated during RUN.
- start while busy=1 is ignored; A/B/Bin changes during RUN have no effect.
- Bin=1 with A=B yields Diff=all-ones, Bout=1.
- Counter width ceil(log2(WIDTH))+1; no wrap beyond WIDTH.

Test Plan:
- Reset, then A=9, B=3, Bin=0, start for 1 cycle:
  - done pulses exactly 9 cycles after the accepting edge.
  - Diff=6, Bout=0, Ovf=0; busy high for 8 cycles.
- A=3, B=6, Bin=0 → Diff=253 (0xFD), Bout=1, Ovf=0.
- A=12, B=8, Bin=1 → Diff=3, Bout=0, Ovf=0.
- A=0, B=0, Bin=1 → Diff=0xFF, Bout=1, Ovf=0.
- A=0x80, B=0x01, Bin=0 → Diff=0x7F, Bout=0, Ovf=1.
- A=0x7F, B=0xFF, Bin=0 → Diff=0x80, Bout=1, Ovf=1.
- Protocol and reset:
  - Start again with new operands at cycle 3 of RUN → ignored; result is still from the first operands.
  - Start asserted in the DONE cycle → accepted back-to-back.
  - rst_n pulsed low mid-RUN → all outputs 0 immediately, no done pulse.
  - After release, the next operation (A=5, B=7, Bin=1 → Diff=0xFD, Bout=1) completes correctly.
